// File: rtl/router_pkg.sv
// router_pkg
//   Shared constants for the router output buffer.
//   Every router_fifo instance uses the same data width, storage depth,
//   header-tag bit position and packet-length field position.
//   No ports; import with "import router_pkg::*;".
package router_pkg;

  // Payload byte width and storage geometry
  localparam int DATA_W    = 8;
  localparam int DEPTH     = 16;
  localparam int ADDR_W    = 4;

  // Each stored word is one payload byte plus one header-tag bit
  localparam int WORD_W    = DATA_W + 1;
  localparam int HDR_BIT   = DATA_W;

  // Payload length field inside a header byte
  localparam int LEN_MSB   = 7;
  localparam int LEN_LSB   = 2;

  // Width of the remaining-bytes counter
  localparam int PKT_CNT_W = 7;

endpackage

// File: rtl/router_fifo_mem.sv
// router_fifo_mem
//   DEPTH x WORD_W storage for router_fifo.
//   Writes are synchronous; reads are combinational, so the parent can
//   register the word it presents. Contents are never cleared; the parent's
//   pointers decide which words are valid.
// Ports:
//   clock    in   rising-edge clock
//   wr_en    in   write strobe, sampled at the edge
//   wr_addr  in   write address
//   wr_data  in   word to store
//   rd_addr  in   read address
//   rd_data  out  word at rd_addr (combinational)
module router_fifo_mem
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage array has no reset: stale words are simply unreachable once the
  // pointers are cleared, which keeps this a plain RAM.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_fifo.sv
// router_fifo
//   Per-destination output buffer of the 1x3 router. Bytes from the
//   router register stage are stored with a header tag bit; the destination
//   port reads them out one cycle after asserting read_enb. A counter loaded
//   from each header tracks the remaining payload and parity bytes so the
//   output can return to zero once the whole packet has left.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-high clear of all state
//   soft_reset  in   synchronous clear (destination timeout)
//   write_enb   in   write request; data_in captured at the edge
//   read_enb    in   read request from the destination port
//   lfd_state   in   current write is a header byte
//   data_in     in   byte to store
//   full        out  no free word
//   empty       out  no stored word
//   data_out    out  registered read data
module router_fifo
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] data_out
);

  localparam logic [ADDR_W:0]      PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [PKT_CNT_W-1:0] CNT_ONE = PKT_CNT_W'(1);

  // Pointers carry one extra wrap bit so full and empty can be told apart
  // when the address bits are equal.
  logic [ADDR_W:0]      wr_ptr;
  logic [ADDR_W:0]      rd_ptr;
  logic [PKT_CNT_W-1:0] pkt_cnt;
  logic [WORD_W-1:0]    rd_word;
  logic                 wr_fire;
  logic                 rd_fire;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // soft_reset wins over any transfer requested in the same cycle
  assign wr_fire = write_enb && !full  && !soft_reset;
  assign rd_fire = read_enb  && !empty && !soft_reset;

  router_fifo_mem u_mem (
    .clock   (clock),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data ({lfd_state, data_in}),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_word)
  );

  // Pointer, packet-counter and output register update. A header read loads
  // the counter with payload length plus one for parity, even if the previous
  // packet was cut short. When the counter has run out and nothing is read,
  // the output is driven back to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
    end else if (soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_fire) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        data_out <= rd_word[DATA_W-1:0];
        if (rd_word[HDR_BIT]) begin
          pkt_cnt <= PKT_CNT_W'(rd_word[LEN_MSB:LEN_LSB]) + CNT_ONE;
        end else if (pkt_cnt != '0) begin
          pkt_cnt <= pkt_cnt - CNT_ONE;
        end
      end else if (pkt_cnt == '0) begin
        data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo
//   Directed and randomized bench for router_fifo. A queue of tagged words
//   plus an output byte and a remaining-bytes count form the reference model.
module tb_router_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       full;
  logic       empty;
  logic [7:0] data_out;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  logic [8:0] model_q[$];
  logic [7:0] model_out = 8'h00;
  int         model_cnt = 0;
  logic [7:0] saved[$];

  router_fifo dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .full       (full),
    .empty      (empty),
    .data_out   (data_out)
  );

  always #5 clock = ~clock;

  // Model one clock edge using occupancy before the edge
  task automatic modelEdge();
    logic [8:0] w;
    bit do_rd;
    bit do_wr;
    if (soft_reset) begin
      model_q.delete();
      model_out = 8'h00;
      model_cnt = 0;
    end else begin
      do_rd = read_enb && (model_q.size() != 0);
      do_wr = write_enb && (model_q.size() != 16);
      if (do_rd) begin
        w = model_q.pop_front();
        model_out = w[7:0];
        if (w[8]) model_cnt = int'(w[7:2]) + 1;
        else if (model_cnt != 0) model_cnt = model_cnt - 1;
      end else if (model_cnt == 0) begin
        model_out = 8'h00;
      end
      if (do_wr) model_q.push_back({lfd_state, data_in});
    end
  endtask

  task automatic checkOutput(input string tag);
    logic exp_empty;
    logic exp_full;
    exp_empty = (model_q.size() == 0);
    exp_full  = (model_q.size() == 16);
    compared++;
    assert (empty === exp_empty) else begin
      mismatched++;
      $error("[TB] FAIL %s empty got %0b want %0b", tag, empty, exp_empty);
    end
    compared++;
    assert (full === exp_full) else begin
      mismatched++;
      $error("[TB] FAIL %s full got %0b want %0b", tag, full, exp_full);
    end
    compared++;
    assert (data_out === model_out) else begin
      mismatched++;
      $error("[TB] FAIL %s data_out got %02h want %02h", tag, data_out, model_out);
    end
  endtask

  // Drive one cycle of inputs, clock it, then check 1 time unit later
  task automatic applyStimulus(input logic we, input logic re, input logic lfd,
                               input logic [7:0] din, input logic sr,
                               input string tag);
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    soft_reset = sr;
    @(posedge clock);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [7:0] pkt[7];
    logic [7:0] b;

    $display("[TB] start");
    // Reset state
    #12;
    checkOutput("reset_state");
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Async reset mid-stream: data_out nonzero, then reset between edges
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 8'h31 + 8'(i), 0, "t1_write");
    applyStimulus(0, 1, 0, 8'h00, 0, "t1_read");
    #2;
    reset = 1'b1;
    model_q.delete();
    model_out = 8'h00;
    model_cnt = 0;
    #1;
    checkOutput("t1_async_reset");
    reset = 1'b0;

    // Header 0x16: 5 payload bytes plus parity, read back one cycle late
    pkt[0] = 8'h16;
    for (int i = 1; i < 6; i++) pkt[i] = 8'($urandom);
    pkt[6] = 8'h5C;
    for (int i = 0; i < 7; i++) applyStimulus(1, 0, (i == 0), pkt[i], 0, "t2_write");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 1, 0, 8'h00, 0, "t2_read");
      compared++;
      assert (data_out === pkt[i]) else begin
        mismatched++;
        $error("[TB] FAIL t2_seq[%0d] got %02h want %02h", i, data_out, pkt[i]);
      end
    end
    applyStimulus(0, 0, 0, 8'h00, 0, "t2_idle_zero");
    compared++;
    assert (data_out === 8'h00) else begin
      mismatched++;
      $error("[TB] FAIL t2_after_parity got %02h want 00", data_out);
    end

    // Fill to 16, drop a 17th write
    saved.delete();
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      saved.push_back(b);
      applyStimulus(1, 0, 0, b, 0, "t3_fill");
    end
    applyStimulus(1, 0, 0, 8'hAA, 0, "t3_drop");

    // At full, simultaneous read and write: only the read happens
    applyStimulus(1, 1, 0, 8'h77, 0, "t4_full_rw");
    compared++;
    assert (data_out === saved[0]) else begin
      mismatched++;
      $error("[TB] FAIL t4_first got %02h want %02h", data_out, saved[0]);
    end
    for (int i = 1; i < 16; i++) begin
      applyStimulus(0, 1, 0, 8'h00, 0, "t3_drain");
      compared++;
      assert (data_out === saved[i]) else begin
        mismatched++;
        $error("[TB] FAIL t3_data[%0d] got %02h want %02h", i, data_out, saved[i]);
      end
    end
    applyStimulus(0, 1, 0, 8'h00, 0, "t3_read_empty");

    // Occupancy 1 with simultaneous read+write across pointer wrap
    applyStimulus(1, 0, 0, 8'h01, 0, "t5_prime");
    for (int i = 0; i < 40; i++) applyStimulus(1, 1, 0, 8'($urandom), 0, "t5_rw");
    applyStimulus(0, 1, 0, 8'h00, 0, "t5_last");

    // soft_reset with stored bytes beats a read
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 8'hC0 + 8'(i), 0, "t6_fill");
    applyStimulus(0, 1, 0, 8'h00, 0, "t6_read_one");
    applyStimulus(0, 1, 0, 8'h00, 1, "t6_soft_reset");

    // Random traffic, including headers and occasional soft_reset
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50),
                    1'($urandom_range(0, 99) < 15), 8'($urandom),
                    1'($urandom_range(0, 99) < 2), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
